// File: rtl/mem_port_arbiter_if.sv
// Bundles the CPU, DMA, DataMemory and peripheral buses around mem_port_arbiter.
// slave = arbiter side, master = surrounding pipeline/DMA/memory side.
`timescale 1ns/1ps
interface mem_port_arbiter_if;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_ack;
    logic [31:0] dma_rdata;

    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        per_rd;
    logic        per_wr;
    logic [31:0] per_addr;
    logic [31:0] per_wdata;
    logic [31:0] per_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata,
        output per_rd, per_wr, per_addr, per_wdata,
        input  per_rdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata,
        input  per_rd, per_wr, per_addr, per_wdata,
        output per_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the DataMemory port between the CPU MEM stage (priority) and a DMA requester.
// Define PERIPH_DECODE_EN to route CPU accesses with addr[30] set to the peripheral bus.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    typedef enum logic {StIdle, StAck} state_e;

    state_e      state_q;
    logic [3:0]  wait_cnt_q;
    logic        dma_ack_q;
    logic [31:0] dma_rdata_q;

    logic per_hit;
    logic cpu_mem;
    logic dma_pend;
    logic dma_gnt;

`ifdef PERIPH_DECODE_EN
    assign per_hit = bus.cpu_addr[30];
`else
    assign per_hit = 1'b0;
`endif

    assign cpu_mem  = (bus.cpu_rd | bus.cpu_wr) & ~per_hit;
    // The request level is ignored during its own ack cycle.
    assign dma_pend = bus.dma_req & ~dma_ack_q;
    assign dma_gnt  = (state_q == StIdle) & dma_pend & (~cpu_mem | (wait_cnt_q == MaxWait));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            wait_cnt_q  <= 4'd0;
            dma_ack_q   <= 1'b0;
            dma_rdata_q <= 32'd0;
        end else begin
            dma_ack_q <= dma_gnt;
            if (dma_gnt) begin
                state_q     <= StAck;
                wait_cnt_q  <= 4'd0;
                dma_rdata_q <= bus.mem_rdata;
            end else begin
                state_q <= StIdle;
                if (dma_pend && cpu_mem && (state_q == StIdle) && (wait_cnt_q != 4'hf)) begin
                    wait_cnt_q <= wait_cnt_q + 4'd1;
                end
            end
        end
    end

    // A granted DMA owns the memory port outright; a CPU memory access that cycle is stalled.
    always_comb begin
        bus.mem_rd    = bus.cpu_rd & ~per_hit;
        bus.mem_wr    = bus.cpu_wr & ~per_hit;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.cpu_stall = 1'b0;
        if (dma_gnt) begin
            bus.mem_rd    = ~bus.dma_we;
            bus.mem_wr    = bus.dma_we;
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
            bus.cpu_stall = cpu_mem;
        end
    end

    assign bus.per_rd    = bus.cpu_rd & per_hit;
    assign bus.per_wr    = bus.cpu_wr & per_hit;
    assign bus.per_addr  = bus.cpu_addr;
    assign bus.per_wdata = bus.cpu_wdata;
    assign bus.cpu_rdata = per_hit ? bus.per_rdata : bus.mem_rdata;

    assign bus.dma_ack   = dma_ack_q;
    assign bus.dma_rdata = dma_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios, randomized traffic, mid-grant reset.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int unsigned MaxWait = 4;
`ifdef PERIPH_DECODE_EN
    localparam bit Decode = 1'b1;
`else
    localparam bit Decode = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_WAIT(MaxWait)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] per_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
    endfunction

    // DataMemory and peripheral models driven by the DUT.
    logic [31:0] dmem [16];
    assign bus.mem_rdata = dmem[bus.mem_addr[5:2]];
    assign bus.per_rdata = per_fn(bus.per_addr);
    always @(posedge clk) if (bus.mem_wr) dmem[bus.mem_addr[5:2]] <= bus.mem_wdata;

    typedef struct packed {
        logic        ack;
        logic        stall;
        logic        mem_rd;
        logic        mem_wr;
        logic        per_rd;
        logic        per_wr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] per_addr;
        logic [31:0] per_wdata;
        logic [31:0] cpu_rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ack_q[$];
    exp_t        e_mon;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: port ownership decided from the arbitration rules.
    logic [31:0] ref_mem [16];
    bit          m_cool;   // previous cycle was a DMA grant, so this one is its ack cycle
    int          m_lost;   // cycles the pending DMA has lost to CPU memory traffic

    bit          mon_en = 1'b0;
    bit          prev_stall = 1'b0;
    int          wait_run = 0;

    bit          dma_busy;
    logic        cur_we;
    logic [31:0] cur_da;
    logic [31:0] cur_dwd;

    function automatic void chk32(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    endfunction

    function automatic void chk1(input string name, input logic act, input logic req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    endfunction

    // Called at posedge+1: drive one cycle, predict, then advance to the next posedge+1.
    task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic req, input logic we,
                        input logic [31:0] da, input logic [31:0] dwd);
        exp_t e;
        bit hit, cmem, pend, gnt;
        bus.cpu_rd    = rd;
        bus.cpu_wr    = wr;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        bus.dma_req   = req;
        bus.dma_we    = we;
        bus.dma_addr  = da;
        bus.dma_wdata = dwd;
        hit  = Decode && a[30];
        cmem = (rd || wr) && !hit;
        pend = req && !m_cool;
        gnt  = pend && (!cmem || m_lost >= int'(MaxWait));
        e.ack       = m_cool;
        e.stall     = gnt && cmem;
        e.mem_rd    = gnt ? !we : (rd && !hit);
        e.mem_wr    = gnt ? we : (wr && !hit);
        e.mem_addr  = gnt ? da : a;
        e.mem_wdata = gnt ? dwd : wd;
        e.per_rd    = rd && hit;
        e.per_wr    = wr && hit;
        e.per_addr  = a;
        e.per_wdata = wd;
        e.cpu_rdata = hit ? per_fn(a) : ref_mem[e.mem_addr[5:2]];
        exp_q.push_back(e);
        if (gnt) ack_q.push_back(ref_mem[da[5:2]]);
        if (e.mem_wr) ref_mem[e.mem_addr[5:2]] = e.mem_wdata;
        if (gnt) m_lost = 0;
        else if (pend && cmem) m_lost++;
        m_cool = gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                chk1("exp_queue_nonempty", 1'b0, 1'b1);
            end else begin
                e_mon = exp_q.pop_front();
                chk1("dma_ack", bus.dma_ack, e_mon.ack);
                chk1("cpu_stall", bus.cpu_stall, e_mon.stall);
                chk1("mem_rd", bus.mem_rd, e_mon.mem_rd);
                chk1("mem_wr", bus.mem_wr, e_mon.mem_wr);
                chk1("per_rd", bus.per_rd, e_mon.per_rd);
                chk1("per_wr", bus.per_wr, e_mon.per_wr);
                chk32("mem_addr", bus.mem_addr, e_mon.mem_addr);
                chk32("mem_wdata", bus.mem_wdata, e_mon.mem_wdata);
                chk32("per_addr", bus.per_addr, e_mon.per_addr);
                chk32("per_wdata", bus.per_wdata, e_mon.per_wdata);
                chk32("cpu_rdata", bus.cpu_rdata, e_mon.cpu_rdata);
            end
            if (bus.dma_ack) begin
                if (ack_q.size() == 0) chk1("ack_expected", bus.dma_ack, 1'b0);
                else chk32("dma_rdata", bus.dma_rdata, ack_q.pop_front());
                chk1("dma_wait_bound", wait_run <= int'(MaxWait) + 1, 1'b1);
                wait_run = 0;
            end else if (bus.dma_req) begin
                wait_run++;
            end
            if (bus.cpu_stall) chk1("stall_single_cycle", prev_stall, 1'b0);
            prev_stall = bus.cpu_stall;
        end
    end

    initial begin
        logic [31:0] a;
        int op;
        reset = 1'b0;
        bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 32'h0; bus.dma_wdata = 32'h0;
        for (int i = 0; i < 16; i++) begin
            dmem[i]    = 32'h0F0F_0001 + 32'(i) * 32'h1111_1111;
            ref_mem[i] = dmem[i];
        end
        m_cool = 1'b0;
        m_lost = 0;
        dma_busy = 1'b0;
        cur_we = 1'b0; cur_da = 32'h0; cur_dwd = 32'h0;

        #3;
        chk1("reset_dma_ack", bus.dma_ack, 1'b0);
        chk32("reset_dma_rdata", bus.dma_rdata, 32'h0);
        chk1("reset_cpu_stall", bus.cpu_stall, 1'b0);
        chk1("reset_mem_rd", bus.mem_rd, 1'b0);
        chk1("reset_mem_wr", bus.mem_wr, 1'b0);
        chk1("reset_per_wr", bus.per_wr, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        mon_en = 1'b1;

        // DMA write 0x10 <- DEADBEEF, then read it back.
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1);

        // Continuous CPU loads against a pending DMA read: forced grant after MaxWait losses.
        for (int k = 0; k < int'(MaxWait) + 1; k++)
            step(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
        step(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1);

        // CPU store stalled by the forced grant, retried next cycle, then read back.
        for (int k = 0; k < int'(MaxWait); k++)
            step(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h18, 32'h0);
        step(1'b0, 1'b1, 32'h20, 32'h1234, 1'b1, 1'b0, 32'h18, 32'h0);
        step(1'b0, 1'b1, 32'h20, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1);

        // Peripheral store with DMA pending.
        step(1'b0, 1'b1, 32'h4000_000C, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h1C, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1);

        // Request held across three transactions with an idle CPU.
        for (int k = 0; k < 6; k++)
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        idle(2);

        // Randomized traffic; requester holds each transaction stable until its ack cycle.
        for (int i = 0; i < 3000; i++) begin
            if (m_cool) dma_busy = 1'b0;
            if (!dma_busy && $urandom_range(0, 9) < 4) begin
                dma_busy = 1'b1;
                cur_we   = 1'($urandom_range(0, 1));
                cur_da   = 32'($urandom_range(0, 15)) << 2;
                cur_dwd  = $urandom;
            end
            op = int'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 3) == 0) a = a | 32'h4000_0000;
            step(op == 1 || op == 3, op == 2, a, $urandom, dma_busy, cur_we, cur_da, cur_dwd);
        end
        for (int k = 0; k < int'(MaxWait) + 4; k++) begin
            if (m_cool) dma_busy = 1'b0;
            step(1'b0, 1'b0, 32'h0, 32'h0, dma_busy, cur_we, cur_da, cur_dwd);
        end

        // Reset asserted inside a DMA read grant cycle.
        mon_en = 1'b0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h18; bus.dma_wdata = 32'h0;
        #2 reset = 1'b0;
        #1;
        chk1("midreset_dma_ack", bus.dma_ack, 1'b0);
        chk32("midreset_dma_rdata", bus.dma_rdata, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        m_cool = 1'b0;
        m_lost = 0;
        prev_stall = 1'b0;
        wait_run = 0;
        exp_q.delete();
        ack_q.delete();
        mon_en = 1'b1;
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h18, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(2);
        mon_en = 1'b0;

        chk32("ack_queue_drained", 32'(ack_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single DataMemory port between the pipeline MEM stage (CPU) and a DMA requester, such as a UART program loader. It also decodes CPU accesses between DataMemory and the peripheral space at 0x40000000. The CPU has priority, and a starvation counter bounds DMA waiting. The block stalls the pipeline for one cycle whenever DMA takes the port from a CPU memory access.

## Interface
- MAX_WAIT, 4, number of consecutive cycles a pending DMA request may lose to CPU memory accesses before it is forced through; legal 0..15.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_rd / cpu_wr  in  1 each  MEM-stage read/write enables (never both high)
- cpu_addr  in  32  MEM-stage byte address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, combinational
- cpu_stall  out  1  hold MEM stage and earlier stages this cycle, combinational
- dma_req  in  1  level request, held until dma_ack
- dma_we  in  1  1 = write, 0 = read; stable while dma_req
- dma_addr, dma_wdata  in  32 each  stable while dma_req
- dma_ack  out  1  one-cycle completion pulse, registered
- dma_rdata  out  32  read result, registered, valid with dma_ack, held until next ack
- mem_rd, mem_wr  out  1 each  to DataMemory
- mem_addr, mem_wdata  out  32 each  to DataMemory
- mem_rdata  in  32  DataMemory combinational read data
- per_rd, per_wr  out  1 each  to peripheral block
- per_addr, per_wdata  out  32 each  to peripheral block
- per_rdata  in  32  peripheral read data

## Operation
- Signal definitions:
  - per_hit = cpu_addr[30].
  - cpu_mem = (cpu_rd|cpu_wr) & ~per_hit.
  - dma_pend = dma_req & ~dma_ack; dma_req is ignored in the ack cycle.
- States: IDLE, ACK.
  - IDLE → ACK on a DMA grant.
  - ACK → IDLE unconditionally.
  - DMA is never granted while in ACK.
- Grant: dma_gnt = (state==IDLE) & dma_pend & (~cpu_mem | wait_cnt==MAX_WAIT).
- On dma_gnt:
  - mem_* carry dma_addr, dma_wdata, mem_wr = dma_we, mem_rd = ~dma_we.
  - cpu_stall = cpu_mem.
  - dma_rdata <= mem_rdata.
  - wait_cnt <= 0.
- Without dma_gnt:
  - mem_* carry the CPU access gated by ~per_hit.
  - cpu_stall = 0.
  - If dma_pend & cpu_mem & state==IDLE, wait_cnt <= wait_cnt+1 (saturating at 15).
- A stalled CPU write never reaches mem_wr.
- Peripheral accesses:
  - per_rd/per_wr = cpu_rd/cpu_wr & per_hit.
  - They proceed concurrently with a DMA grant and never stall.
- cpu_rdata = per_hit ? per_rdata : mem_rdata.
- per_addr/per_wdata = cpu_addr/cpu_wdata, unconditionally.

## Timing
- Reset values:
  - state = IDLE, wait_cnt = 0.
  - dma_ack = 0, dma_rdata = 0.
  - cpu_stall, mem_rd, mem_wr, per_rd, per_wr are 0 whenever inputs are idle.
- DMA latency:
  - Grant in cycle N; the write commits at the end of N.
  - dma_ack and dma_rdata are valid in N+1.
  - Minimum: request in cycle N, ack in N+1.
- Maximum DMA wait under continuous CPU memory traffic: MAX_WAIT cycles, then granted.
- MAX_WAIT=0: DMA wins whenever pending.
- CPU stall never exceeds 1 consecutive cycle, because the ACK state blocks back-to-back DMA grants.
- Requester may keep dma_req high after ack for a new transaction; it is sampled again from N+2.
- Reset mid-transaction:
  - An ungranted request is simply re-arbitrated after reset.
  - A granted-but-unacked transaction loses its ack; the write may already be committed.

## Configuration
- PERIPH_DECODE_EN defined: decode as above.
- PERIPH_DECODE_EN undefined:
  - per_hit is forced to 0, so every CPU access goes to DataMemory.
  - per_rd and per_wr are tied 0.
  - cpu_rdata = mem_rdata.

## Test plan
- Idle CPU, DMA write 0x0000_0010 ← 0xDEAD_BEEF, then DMA read 0x10 → mem_wr for one cycle; ack next cycle; read returns dma_rdata = 0xDEADBEEF one cycle after its grant.
- CPU lw every cycle, DMA read pending, MAX_WAIT=4 → CPU served 4 cycles, grant on cycle 5 with cpu_stall=1 for exactly that cycle; ack in cycle 6; wait_cnt back to 0.
- CPU sw 0x20 ← 0x1234 stalled by DMA grant → no mem_wr from CPU in the stall cycle; the write commits the following cycle; readback 0x1234.
- CPU sw to 0x4000_000C with DMA pending → per_wr=1, DMA granted the same cycle, cpu_stall=0; with PERIPH_DECODE_EN undefined, the same store goes to mem_wr and per_wr stays 0.
- dma_req held high across 3 transactions, no CPU traffic → acks at cycles N+1, N+3, N+5; never two grants in consecutive cycles.
- reset asserted low in the grant cycle → dma_ack=0 and dma_rdata=0 immediately; after release with dma_req still high, grant next IDLE cycle.
